exc_sequencer: RTL and testbench

Multi-cycle controller that sits between the exception priority encoder and CP0/fetch. It accepts one encoded exception or ERET per episode and holds the pipeline flushed. When enabled, it waits for outstanding data-bus transactions to drain. It then issues a single-cycle CP0 update (ExcCode, EPC, BD, BadVAddr, EXL) followed by a single-cycle fetch redirect to the vector or the EPC.

---
 rtl/exc_sequencer_if.sv | 42 ++++
 rtl/exc_sequencer.sv | 153 +++++++++++++++
 tb/tb_exc_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/exc_sequencer_if.sv
// Exception sequencer bundle: encoder/CP0 inputs, CP0 commit and fetch redirect outputs.
// master drives the exception request side; slave is the sequencer.
interface exc_sequencer_if;
   logic        exc_flag;
   logic [3:0]  exc_type;
   logic        exc_save;
   logic [31:0] exc_baddr;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic        status_bev;
   logic        status_exl;
   logic [31:0] cp0_epc_i;
   logic        mem_busy;
   logic        flush;
   logic        busy;
   logic        cp0_exc_we;
   logic [4:0]  cp0_exccode;
   logic        cp0_epc_we;
   logic [31:0] cp0_epc;
   logic        cp0_bd;
   logic        cp0_badv_we;
   logic [31:0] cp0_badvaddr;
   logic        cp0_exl_clr;
   logic        redir_valid;
   logic [31:0] redir_pc;

   modport master (
      output exc_flag, exc_type, exc_save, exc_baddr, exc_pc, exc_bd,
      output status_bev, status_exl, cp0_epc_i, mem_busy,
      input  flush, busy, cp0_exc_we, cp0_exccode, cp0_epc_we, cp0_epc,
      input  cp0_bd, cp0_badv_we, cp0_badvaddr, cp0_exl_clr,
      input  redir_valid, redir_pc
   );

   modport slave (
      input  exc_flag, exc_type, exc_save, exc_baddr, exc_pc, exc_bd,
      input  status_bev, status_exl, cp0_epc_i, mem_busy,
      output flush, busy, cp0_exc_we, cp0_exccode, cp0_epc_we, cp0_epc,
      output cp0_bd, cp0_badv_we, cp0_badvaddr, cp0_exl_clr,
      output redir_valid, redir_pc
   );
endinterface

// File: rtl/exc_sequencer.sv
// Exception/ERET sequencer: capture, optional bus drain, CP0 commit, fetch redirect.
// Define EXC_DRAIN_EN to wait for outstanding data-bus transactions before commit.
module exc_sequencer #(
   parameter logic [31:0] BEV_BASE = 32'hBFC00200,
   parameter logic [31:0] NRM_BASE = 32'h80000000
) (
   input logic          clk,
   input logic          resetn,
   exc_sequencer_if.slave bus
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DRAIN    = 2'd1;
   localparam logic [1:0] COMMIT   = 2'd2;
   localparam logic [1:0] REDIRECT = 2'd3;

   localparam logic [3:0] T_INTR = 4'd0;
   localparam logic [3:0] T_ADE  = 4'd1;
   localparam logic [3:0] T_TLBR = 4'd2;
   localparam logic [3:0] T_TLBI = 4'd3;
   localparam logic [3:0] T_TLBM = 4'd4;
   localparam logic [3:0] T_IBE  = 4'd5;
   localparam logic [3:0] T_DBE  = 4'd6;
   localparam logic [3:0] T_CPU  = 4'd7;
   localparam logic [3:0] T_RI   = 4'd8;
   localparam logic [3:0] T_OV   = 4'd9;
   localparam logic [3:0] T_TRAP = 4'd10;
   localparam logic [3:0] T_SYSC = 4'd11;
   localparam logic [3:0] T_BP   = 4'd12;
   localparam logic [3:0] T_ERET = 4'd13;
   localparam logic [3:0] T_NONE = 4'd15;

   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic        accept;
   logic        go_drain;

   logic        eret_q;
   logic        epc_en_q;
   logic        badv_en_q;
   logic [4:0]  code_q;
   logic [31:0] epc_q;
   logic        bd_q;
   logic [31:0] badv_q;
   logic [31:0] rpc_q;

   logic        is_eret;
   logic        badv_sel;
   logic [4:0]  code_nxt;
   logic [31:0] epc_nxt;
   logic [31:0] vec_base;
   logic [31:0] vec_off;
   logic [31:0] rpc_nxt;

   assign accept = (state == IDLE) && bus.exc_flag &&
                   (bus.exc_type != T_NONE);

`ifdef EXC_DRAIN_EN
   assign go_drain = bus.mem_busy;
`else
   assign go_drain = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (accept) state_nxt = go_drain ? DRAIN : COMMIT;
         DRAIN:    if (!bus.mem_busy) state_nxt = COMMIT;
         COMMIT:   state_nxt = REDIRECT;
         REDIRECT: state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      code_nxt = 5'd0;
      case (bus.exc_type)
         T_INTR:         code_nxt = 5'd0;
         T_ADE:          code_nxt = bus.exc_save ? 5'd5 : 5'd4;
         T_TLBR, T_TLBI: code_nxt = bus.exc_save ? 5'd3 : 5'd2;
         T_TLBM:         code_nxt = 5'd1;
         T_IBE:          code_nxt = 5'd6;
         T_DBE:          code_nxt = 5'd7;
         T_CPU:          code_nxt = 5'd11;
         T_RI:           code_nxt = 5'd10;
         T_OV:           code_nxt = 5'd12;
         T_TRAP:         code_nxt = 5'd13;
         T_SYSC:         code_nxt = 5'd8;
         T_BP:           code_nxt = 5'd9;
         default:        code_nxt = 5'd0;
      endcase
   end

   assign is_eret  = (bus.exc_type == T_ERET);
   assign badv_sel = (bus.exc_type == T_ADE)  ||
                     (bus.exc_type == T_TLBR) ||
                     (bus.exc_type == T_TLBI) ||
                     (bus.exc_type == T_TLBM);

   // Delay-slot faults restart at the branch; wraps modulo 2^32.
   assign epc_nxt  = bus.exc_bd ? (bus.exc_pc - 32'd4) : bus.exc_pc;

   // TLB refill with EXL clear takes the dedicated refill vector.
   assign vec_base = bus.status_bev ? BEV_BASE : NRM_BASE;
   assign vec_off  = ((bus.exc_type == T_TLBR) && !bus.status_exl) ?
                     32'h0000_0000 : 32'h0000_0180;
   assign rpc_nxt  = is_eret ? bus.cp0_epc_i : (vec_base + vec_off);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         eret_q    <= 1'b0;
         epc_en_q  <= 1'b0;
         badv_en_q <= 1'b0;
         code_q    <= 5'd0;
         epc_q     <= 32'd0;
         bd_q      <= 1'b0;
         badv_q    <= 32'd0;
         rpc_q     <= 32'd0;
      end else if (accept) begin
         eret_q    <= is_eret;
         epc_en_q  <= !is_eret && !bus.status_exl;
         badv_en_q <= !is_eret && badv_sel;
         code_q    <= code_nxt;
         epc_q     <= epc_nxt;
         bd_q      <= bus.exc_bd;
         badv_q    <= bus.exc_baddr;
         rpc_q     <= rpc_nxt;
      end
   end

   assign bus.busy         = (state != IDLE);
   assign bus.flush        = (state != IDLE);
   assign bus.cp0_exc_we   = (state == COMMIT) && !eret_q;
   assign bus.cp0_epc_we   = (state == COMMIT) && epc_en_q;
   assign bus.cp0_badv_we  = (state == COMMIT) && badv_en_q;
   assign bus.cp0_exl_clr  = (state == COMMIT) && eret_q;
   assign bus.redir_valid  = (state == REDIRECT);

   assign bus.cp0_exccode  = code_q;
   assign bus.cp0_epc      = epc_q;
   assign bus.cp0_bd       = bd_q;
   assign bus.cp0_badvaddr = badv_q;
   assign bus.redir_pc     = rpc_q;

endmodule

// File: tb/tb_exc_sequencer.sv
// Scoreboard bench for exc_sequencer: directed episodes, expected pulses queued
// with their arrival time and checked by an independent negedge monitor.
module tb_exc_sequencer;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   exc_sequencer_if bus ();

   exc_sequencer dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus.slave)
   );

   typedef struct {
      time         t;
      logic [4:0]  pulses;
      logic        chk;
      logic [4:0]  code;
      logic [31:0] epc;
      logic        bd;
      logic [31:0] badv;
      logic [31:0] rpc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;

   // pulses = {exc_we, epc_we, badv_we, exl_clr, redir_valid}
   always @(negedge clk) begin
      logic [4:0] p;
      exp_t       e;
      p = {bus.cp0_exc_we, bus.cp0_epc_we, bus.cp0_badv_we,
           bus.cp0_exl_clr, bus.redir_valid};
      if (p != 5'b0) begin
         checks++;
         if (q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse t=%0t got=%b required=none",
                     $time, p);
         end else begin
            e = q.pop_front();
            if ($time != e.t || p != e.pulses || bus.redir_pc != e.rpc ||
                (e.chk && (bus.cp0_exccode != e.code ||
                           bus.cp0_epc != e.epc ||
                           bus.cp0_bd != e.bd ||
                           bus.cp0_badvaddr != e.badv))) begin
               failures++;
               $display("FAIL event got t=%0t p=%b code=%0d epc=%h bd=%b badv=%h rpc=%h required t=%0t p=%b code=%0d epc=%h bd=%b badv=%h rpc=%h",
                        $time, p, bus.cp0_exccode, bus.cp0_epc, bus.cp0_bd,
                        bus.cp0_badvaddr, bus.redir_pc, e.t, e.pulses,
                        e.code, e.epc, e.bd, e.badv, e.rpc);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [127:0] got,
                      input logic [127:0] req);
      checks++;
      if (got !== req) begin
         failures++;
         $display("FAIL %s got=%h required=%h", name, got, req);
      end
   endtask

   task automatic push(input time t, input logic [4:0] p, input logic c,
                       input logic [4:0] code, input logic [31:0] epc,
                       input logic bd, input logic [31:0] badv,
                       input logic [31:0] rpc);
      exp_t e;
      e.t = t; e.pulses = p; e.chk = c; e.code = code;
      e.epc = epc; e.bd = bd; e.badv = badv; e.rpc = rpc;
      q.push_back(e);
   endtask

   task automatic drive(input logic [3:0] ty, input logic sv,
                        input logic [31:0] ba, input logic [31:0] pc,
                        input logic bd, input logic bev, input logic exl,
                        input logic [31:0] epci);
      bus.exc_flag = 1'b1; bus.exc_type = ty; bus.exc_save = sv;
      bus.exc_baddr = ba; bus.exc_pc = pc; bus.exc_bd = bd;
      bus.status_bev = bev; bus.status_exl = exl; bus.cp0_epc_i = epci;
   endtask

   // Episode with mem_busy low: commit at accept+5ns, redirect at +15ns.
   task automatic episode(input logic [3:0] ty, input logic sv,
                          input logic [31:0] ba, input logic [31:0] pc,
                          input logic bd, input logic bev, input logic exl,
                          input logic [31:0] epci, input logic [4:0] cp,
                          input logic c, input logic [4:0] code,
                          input logic [31:0] epc, input logic [31:0] rpc);
      time t0;
      @(negedge clk);
      drive(ty, sv, ba, pc, bd, bev, exl, epci);
      @(posedge clk);
      t0 = $time;
      push(t0 + 5, cp, c, code, epc, bd, ba, rpc);
      push(t0 + 15, 5'b00001, c, code, epc, bd, ba, rpc);
      #1 bus.exc_flag = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   function automatic logic [140:0] outs();
      return {bus.flush, bus.busy, bus.cp0_exc_we, bus.cp0_epc_we,
              bus.cp0_badv_we, bus.cp0_exl_clr, bus.redir_valid,
              bus.cp0_exccode, bus.cp0_epc, bus.cp0_bd,
              bus.cp0_badvaddr, bus.redir_pc};
   endfunction

   initial begin
      time t0;
      resetn = 1'b0;
      bus.mem_busy = 1'b0;
      drive(4'd15, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      bus.exc_flag = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_outputs", 128'(outs()), 128'd0);
      chk("reset_outputs_hi", 128'(outs() >> 128), 128'd0);
      resetn = 1'b1;
      @(negedge clk);

      // AdE store
      episode(4'd1, 1'b1, 32'h0000_0003, 32'h8000_1000, 1'b0, 1'b0, 1'b0,
              32'd0, 5'b11100, 1'b1, 5'd5, 32'h8000_1000, 32'h8000_0180);
      // TLBR load in delay slot, BEV=1, EXL=0: refill vector
      episode(4'd2, 1'b0, 32'h0040_1000, 32'h8000_2004, 1'b1, 1'b1, 1'b0,
              32'd0, 5'b11100, 1'b1, 5'd2, 32'h8000_2000, 32'hBFC0_0200);
      // Same TLBR with EXL=1: no EPC write, general vector
      episode(4'd2, 1'b0, 32'h0040_1000, 32'h8000_2004, 1'b1, 1'b1, 1'b1,
              32'd0, 5'b10100, 1'b1, 5'd2, 32'h8000_2000, 32'hBFC0_0380);
      // ERET
      episode(4'd13, 1'b0, 32'h1111_1111, 32'h8000_7000, 1'b0, 1'b0, 1'b1,
              32'h8000_4000, 5'b00010, 1'b0, 5'd0, 32'd0, 32'h8000_4000);
      // Intr, BEV=1
      episode(4'd0, 1'b0, 32'h0, 32'h8000_0010, 1'b0, 1'b1, 1'b0,
              32'd0, 5'b11000, 1'b1, 5'd0, 32'h8000_0010, 32'hBFC0_0380);
      // TLBM store, EXL=1: code ignores save
      episode(4'd4, 1'b1, 32'hDEAD_0000, 32'h8000_6000, 1'b0, 1'b1, 1'b1,
              32'd0, 5'b10100, 1'b1, 5'd1, 32'h8000_6000, 32'hBFC0_0380);
      // TLBI store
      episode(4'd3, 1'b1, 32'h1234_5000, 32'h8000_5008, 1'b0, 1'b0, 1'b0,
              32'd0, 5'b11100, 1'b1, 5'd3, 32'h8000_5008, 32'h8000_0180);
      // Ov in delay slot at pc 0: EPC wraps
      episode(4'd9, 1'b0, 32'h0, 32'h0000_0000, 1'b1, 1'b0, 1'b0,
              32'd0, 5'b11000, 1'b1, 5'd12, 32'hFFFF_FFFC, 32'h8000_0180);

      // NoExc is ignored
      @(negedge clk);
      drive(4'd15, 1'b0, 32'h0, 32'h8000_9000, 1'b0, 1'b0, 1'b0, 32'd0);
      @(negedge clk);
      bus.exc_flag = 1'b0;
      chk("noexc_busy", 128'(bus.busy), 128'd0);

      // Drain: mem_busy high for 5 edges, second request while busy
      @(negedge clk);
      drive(4'd11, 1'b0, 32'h0, 32'h8000_3000, 1'b0, 1'b0, 1'b0, 32'd0);
      bus.mem_busy = 1'b1;
      @(posedge clk);
      t0 = $time;
`ifdef EXC_DRAIN_EN
      push(t0 + 55, 5'b11000, 1'b1, 5'd8, 32'h8000_3000, 1'b0, 32'h0,
           32'h8000_0180);
      push(t0 + 65, 5'b00001, 1'b1, 5'd8, 32'h8000_3000, 1'b0, 32'h0,
           32'h8000_0180);
`else
      push(t0 + 5, 5'b11000, 1'b1, 5'd8, 32'h8000_3000, 1'b0, 32'h0,
           32'h8000_0180);
      push(t0 + 15, 5'b00001, 1'b1, 5'd8, 32'h8000_3000, 1'b0, 32'h0,
           32'h8000_0180);
`endif
      #1 bus.exc_flag = 1'b0;
      @(negedge clk);
      chk("drain_flush_busy", 128'({bus.flush, bus.busy}), 128'd3);
      @(negedge clk);
      drive(4'd0, 1'b0, 32'h0, 32'h8000_8000, 1'b0, 1'b0, 1'b0, 32'd0);
      chk("drain_flush2", 128'(bus.flush), 128'd1);
      @(negedge clk);
      bus.exc_flag = 1'b0;
`ifdef EXC_DRAIN_EN
      chk("drain_flush3", 128'(bus.flush), 128'd1);
`else
      chk("drain_flush3", 128'(bus.flush), 128'd0);
`endif
      repeat (2) @(negedge clk);
      bus.mem_busy = 1'b0;
      repeat (5) @(negedge clk);
      chk("drain_idle", 128'(bus.busy), 128'd0);

      // Reset mid-episode aborts
      @(negedge clk);
      drive(4'd12, 1'b0, 32'h5, 32'h8000_A000, 1'b0, 1'b0, 1'b0, 32'd0);
      bus.mem_busy = 1'b1;
      @(posedge clk);
      t0 = $time;
`ifndef EXC_DRAIN_EN
      push(t0 + 5, 5'b11000, 1'b1, 5'd9, 32'h8000_A000, 1'b0, 32'h5,
           32'h8000_0180);
`endif
      #1 bus.exc_flag = 1'b0;
      #11 resetn = 1'b0;
      #1;
      chk("abort_outputs", 128'(outs()), 128'd0);
      chk("abort_outputs_hi", 128'(outs() >> 128), 128'd0);
      bus.mem_busy = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_idle", 128'(bus.busy), 128'd0);

      repeat (3) @(negedge clk);
      chk("queue_empty", 128'(q.size()), 128'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout t=%0t required=finish", $time);
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
